game_controller: RTL
====================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter ROUNDS, default 5, regulation rounds; one round is one SHOOTER kick followed by one KEEPER kick.
REQ-002 Parameter HOLD_CYCLES, default 65_000_000, number of clk cycles a kick result is held before the state advances.
REQ-003 Parameter MAX_ROUNDS, default 15, round_counter ceiling.
REQ-004 Clocking: one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 Port clk, input, 1, system clock.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port btn_start, input, 1, start/confirm level, synchronous to clk.
REQ-008 Port btn_mode, input, 1, mode-toggle level, synchronous to clk.
REQ-009 Port shot_done, input, 1, single-cycle pulse: current kick resolved.
REQ-010 Port shot_goal, input, 1, qualifies shot_done; 1 = ball in net.
REQ-011 Port out_control, control_if.out, driving game_state (game_pkg enum), game_mode (SOLO/MULTI), score (4-bit player goals), round_counter (4-bit), is_scored (1).
REQ-012 Port opp_score, output, 4, opponent goals.

Function
REQ-013 Outputs SHALL be registered; no combinational input-to-output path.
REQ-014 Edge detection: btn_start and btn_mode SHALL act only on a rising edge (registered previous value), one action per edge.
REQ-015 FSM states: START, SHOOTER, KEEPER, WINNER, LOOSER, with an internal hold flag inside SHOOTER/KEEPER; game_state SHALL equal the FSM state.
REQ-016 START: a btn_mode rise toggles game_mode; a btn_start rise clears score, opp_score, round_counter and is_scored, and moves to SHOOTER on the next cycle.
REQ-017 SHOOTER, not holding: shot_done=1 sets is_scored=shot_goal, increments score if shot_goal, loads the hold counter with HOLD_CYCLES-1 and sets hold.
REQ-018 KEEPER, not holding: shot_done=1 sets is_scored=shot_goal, increments opp_score if shot_goal, increments round_counter, loads the hold counter and sets hold.
REQ-019 While holding: shot_done, btn_start and btn_mode SHALL be ignored; the counter decrements each cycle. On the cycle the counter is 0: hold clears, is_scored clears, and the state advances.
REQ-020 Advance from SHOOTER: always to KEEPER.
REQ-021 Advance from KEEPER, checked in this order:
  - round_counter<ROUNDS: to SHOOTER.
  - score>opp_score: to WINNER.
  - score<opp_score: to LOOSER.
  - tied and round_counter<MAX_ROUNDS: to SHOOTER (sudden death).
  - tied and round_counter==MAX_ROUNDS: to LOOSER.
REQ-022 Counter width: round_counter, score and opp_score never exceed MAX_ROUNDS and SHALL NOT wrap.
REQ-023 WINNER/LOOSER: outputs are frozen; a btn_start rise returns to START with game_mode retained and all counters cleared.
REQ-024 btn_start is ignored in SHOOTER/KEEPER; shot_done is ignored outside SHOOTER/KEEPER.
REQ-025 shot_done and a btn_mode rise arriving in the same cycle: the shot is processed, the mode change is ignored.

Reset
REQ-026 rst_n=0 SHALL, asynchronously, force:
  - game_state=START, game_mode=MULTI.
  - score=0, opp_score=0, round_counter=0, is_scored=0.
  - hold=0, hold counter=0, edge-detect registers=0.
REQ-027 Reset asserted mid-hold or mid-match SHALL abort the match; after release the block waits in START for a btn_start rise.

Verification (HOLD_CYCLES=4, ROUNDS=5)
REQ-028 Reset then btn_mode rise -> game_mode=SOLO; a second rise -> MULTI; holding btn_mode high for 10 cycles -> exactly one toggle.
REQ-029 btn_start rise, then SHOOTER shot_done with shot_goal=1 -> score=1 and is_scored=1 for exactly 4 cycles, then game_state=KEEPER and is_scored=0.
REQ-030 Five rounds: player scores 5, opponent scores 3 -> round_counter=5, WINNER after the final hold; a btn_start rise -> START with counters 0.
REQ-031 Tied 3-3 after 5 rounds; round 6 player misses, opponent scores -> LOOSER with round_counter=6. Tied through round 15 -> LOOSER with round_counter=15.
REQ-032 shot_done pulses during hold -> no counter change. Reset mid-hold in KEEPER -> START with all counters 0 at once.

Source files
------------

// File: rtl/game_controller.sv
// Penalty shoot-out game controller: START -> alternating SHOOTER/KEEPER kicks with a
// held result display -> WINNER/LOOSER, with registered outputs and edge-detected buttons.

package game_pkg;
  typedef enum logic [2:0] {START, SHOOTER, KEEPER, WINNER, LOOSER} state_t;
  typedef enum logic {SOLO = 1'b0, MULTI = 1'b1} mode_t;
endpackage

interface control_if;
  game_pkg::state_t game_state;
  game_pkg::mode_t  game_mode;
  logic [3:0]       score;
  logic [3:0]       round_counter;
  logic             is_scored;

  modport out (output game_state, game_mode, score, round_counter, is_scored);
  modport in  (input  game_state, game_mode, score, round_counter, is_scored);
endinterface

module game_controller
  import game_pkg::*;
#(
  parameter int ROUNDS      = 5,
  parameter int HOLD_CYCLES = 65_000_000,
  parameter int MAX_ROUNDS  = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       shot_done,
  input  logic       shot_goal,
  control_if.out     out_control,
  output logic [3:0] opp_score
);

  localparam int            HW        = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [3:0]    ROUNDS_L  = 4'(ROUNDS);
  localparam logic [3:0]    MAX_L     = 4'(MAX_ROUNDS);

  state_t        state, state_nxt;
  mode_t         mode, mode_nxt;
  logic [3:0]    score, score_nxt;
  logic [3:0]    opp_q, opp_nxt;
  logic [3:0]    round_q, round_nxt;
  logic          scored, scored_nxt;
  logic          hold, hold_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          start_q, mode_q;
  logic          start_rise, mode_rise;

  assign start_rise = btn_start & ~start_q;
  assign mode_rise  = btn_mode & ~mode_q;

  // Counters saturate at MAX_ROUNDS so a long sudden death can never wrap the display.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v < MAX_L) ? v + 4'd1 : v;
  endfunction

  function automatic state_t keeper_next(input logic [3:0] rc,
                                         input logic [3:0] sc,
                                         input logic [3:0] op);
    state_t nxt;
    if (rc < ROUNDS_L)   nxt = SHOOTER;
    else if (sc > op)    nxt = WINNER;
    else if (sc < op)    nxt = LOOSER;
    else if (rc < MAX_L) nxt = SHOOTER;
    else                 nxt = LOOSER;
    return nxt;
  endfunction

  always_comb begin
    state_nxt    = state;
    mode_nxt     = mode;
    score_nxt    = score;
    opp_nxt      = opp_q;
    round_nxt    = round_q;
    scored_nxt   = scored;
    hold_nxt     = hold;
    hold_cnt_nxt = hold_cnt;

    case (state)
      START: begin
        if (mode_rise)
          mode_nxt = (mode == SOLO) ? MULTI : SOLO;
        if (start_rise) begin
          score_nxt  = '0;
          opp_nxt    = '0;
          round_nxt  = '0;
          scored_nxt = 1'b0;
          state_nxt  = SHOOTER;
        end
      end

      SHOOTER, KEEPER: begin
        if (hold) begin
          if (hold_cnt == '0) begin
            hold_nxt   = 1'b0;
            scored_nxt = 1'b0;
            state_nxt  = (state == SHOOTER) ? KEEPER : keeper_next(round_q, score, opp_q);
          end else begin
            hold_cnt_nxt = hold_cnt - 1'b1;
          end
        end else if (shot_done) begin
          scored_nxt   = shot_goal;
          hold_nxt     = 1'b1;
          hold_cnt_nxt = HOLD_LOAD;
          if (state == SHOOTER) begin
            if (shot_goal) score_nxt = sat_inc(score);
          end else begin
            if (shot_goal) opp_nxt = sat_inc(opp_q);
            round_nxt = sat_inc(round_q);
          end
        end
      end

      WINNER, LOOSER: begin
        if (start_rise) begin
          score_nxt  = '0;
          opp_nxt    = '0;
          round_nxt  = '0;
          scored_nxt = 1'b0;
          state_nxt  = START;
        end
      end

      default: state_nxt = START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= START;
      mode     <= MULTI;
      score    <= '0;
      opp_q    <= '0;
      round_q  <= '0;
      scored   <= 1'b0;
      hold     <= 1'b0;
      hold_cnt <= '0;
      start_q  <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mode     <= mode_nxt;
      score    <= score_nxt;
      opp_q    <= opp_nxt;
      round_q  <= round_nxt;
      scored   <= scored_nxt;
      hold     <= hold_nxt;
      hold_cnt <= hold_cnt_nxt;
      start_q  <= btn_start;
      mode_q   <= btn_mode;
    end
  end

  assign out_control.game_state    = state;
  assign out_control.game_mode     = mode;
  assign out_control.score         = score;
  assign out_control.round_counter = round_q;
  assign out_control.is_scored     = scored;
  assign opp_score                 = opp_q;

endmodule
